noise_injection_ctrl: RTL

- Sequences injection of CLT Gaussian noise samples into the simulated echo stream ahead of the pulse-compression matched filter.
- Per pulse, it waits a warm-up interval, then passes cfg_len echo samples through.
- Each accepted sample has a gain-shifted noise sample added, with saturation.
- Upstream and downstream use a valid/ready stream interface. The noise generator free-runs and is sampled once per accepted echo sample.

---
 rtl/noise_inj_pkg.sv | 21 ++
 rtl/noise_inj_sat_add.sv | 33 +++
 rtl/noise_injection_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/noise_inj_pkg.sv
// Shared types and constants for noise_injection_ctrl and its saturating adder.
package noise_inj_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int NOISE_W_DEF = 5;
   localparam int LEN_W_DEF   = 12;
   localparam int WARMUP_DEF  = 32;

   localparam int SHIFT_MAX = DATA_W_DEF - NOISE_W_DEF;

   localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
   localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      RUN,
      FLUSH
   } state_t;

endpackage

// File: rtl/noise_inj_sat_add.sv
// Combinational noise scaling (clamped left shift), widened add and saturation.
module noise_inj_sat_add
   import noise_inj_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NOISE_W   = NOISE_W_DEF,
   parameter int SHIFT_LIM = SHIFT_MAX
)
(
   input  logic [DATA_W-1:0]  i_data,
   input  logic [NOISE_W-1:0] i_noise,
   input  logic [3:0]         i_shift,
   input  logic               i_bypass,
   output logic [DATA_W-1:0]  o_sum,
   output logic               o_sat
);

   logic [3:0]        w_shiftEff;
   logic [DATA_W-1:0] w_noiseExt;
   logic [DATA_W-1:0] w_noiseSh;
   logic [DATA_W:0]   w_sumWide;

   // Clamping the shift keeps the largest noise sample inside DATA_W bits.
   assign w_shiftEff = (int'(i_shift) > SHIFT_LIM) ? 4'(SHIFT_LIM) : i_shift;
   assign w_noiseExt = {{(DATA_W-NOISE_W){i_noise[NOISE_W-1]}}, i_noise};
   assign w_noiseSh  = i_bypass ? '0 : (w_noiseExt << w_shiftEff);
   assign w_sumWide  = {i_data[DATA_W-1], i_data} + {w_noiseSh[DATA_W-1], w_noiseSh};

   assign o_sat = w_sumWide[DATA_W] ^ w_sumWide[DATA_W-1];
   assign o_sum = !o_sat ? w_sumWide[DATA_W-1:0] :
                  (w_sumWide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});

endmodule

// File: rtl/noise_injection_ctrl.sv
// Per-pulse noise injection sequencer: warm-up, gated pass-through with noise, flush.
// Optional macro NOISE_INJ_STATS_EN enables the saturation counter on o_sat_cnt.
module noise_injection_ctrl
   import noise_inj_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int NOISE_W       = NOISE_W_DEF,
   parameter int LEN_W         = LEN_W_DEF,
   parameter int WARMUP_CYCLES = WARMUP_DEF
)
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic [3:0]         i_cfg_shift,
   input  logic               i_cfg_bypass,
   input  logic [NOISE_W-1:0] i_noise_in,
   input  logic               i_s_valid,
   output logic               o_s_ready,
   input  logic [DATA_W-1:0]  i_s_data,
   output logic               o_m_valid,
   input  logic               i_m_ready,
   output logic [DATA_W-1:0]  o_m_data,
   output logic               o_m_last,
   output logic               o_busy,
   output logic               o_done,
   output logic [15:0]        o_sat_cnt
);

   localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

   state_t              r_state;
   logic [LEN_W-1:0]    r_len;
   logic [3:0]          r_shift;
   logic                r_bypass;
   logic [LEN_W-1:0]    r_cnt;
   logic [WARM_W-1:0]   r_warm;
   logic                r_mValid;
   logic [DATA_W-1:0]   r_mData;
   logic                r_mLast;
   logic                r_done;

   logic                w_xfer;
   logic                w_isLast;
   logic                w_startAcc;
   logic [DATA_W-1:0]   w_sum;
   logic                w_sat;

   assign o_s_ready  = (r_state == RUN) && (!r_mValid || i_m_ready);
   assign w_xfer     = i_s_valid && o_s_ready;
   assign w_isLast   = (r_cnt == r_len - LEN_W'(1));
   assign w_startAcc = i_start && (r_state == IDLE);

   assign o_m_valid = r_mValid;
   assign o_m_data  = r_mData;
   assign o_m_last  = r_mLast;
   assign o_busy    = (r_state != IDLE);
   assign o_done    = r_done;

   noise_inj_sat_add #(
      .DATA_W    (DATA_W),
      .NOISE_W   (NOISE_W),
      .SHIFT_LIM (DATA_W - NOISE_W)
   ) u_satAdd (
      .i_data   (i_s_data),
      .i_noise  (i_noise_in),
      .i_shift  (r_shift),
      .i_bypass (r_bypass),
      .o_sum    (w_sum),
      .o_sat    (w_sat)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_shift  <= '0;
         r_bypass <= 1'b0;
         r_cnt    <= '0;
         r_warm   <= '0;
         r_mValid <= 1'b0;
         r_mData  <= '0;
         r_mLast  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Output register holds while stalled; drains when downstream takes it.
         if (w_xfer) begin
            r_mValid <= 1'b1;
            r_mData  <= w_sum;
            r_mLast  <= w_isLast;
         end else if (i_m_ready) begin
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_len    <= i_cfg_len;
                  r_shift  <= i_cfg_shift;
                  r_bypass <= i_cfg_bypass;
                  r_cnt    <= '0;
                  r_warm   <= '0;
                  if (i_cfg_len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= WARMUP;
                  end
               end
            end
            WARMUP: begin
               if (r_warm == WARM_W'(WARMUP_CYCLES - 1)) begin
                  r_state <= RUN;
               end else begin
                  r_warm <= r_warm + WARM_W'(1);
               end
            end
            RUN: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (w_isLast) begin
                     r_state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (!r_mValid || i_m_ready) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef NOISE_INJ_STATS_EN
   logic [15:0] r_satCnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_satCnt <= '0;
      end else if (w_startAcc) begin
         r_satCnt <= '0;
      end else if (w_xfer && w_sat && (r_satCnt != 16'hFFFF)) begin
         r_satCnt <= r_satCnt + 16'd1;
      end
   end

   assign o_sat_cnt = r_satCnt;
`else
   logic w_unusedSat;
   logic w_unusedStart;

   assign w_unusedSat   = w_sat;
   assign w_unusedStart = w_startAcc;
   assign o_sat_cnt     = '0;
`endif

endmodule
